// File: rtl/kernel_stream_source.sv
// Reads NELEMS words in address order from a 1-cycle-latency buffer and streams
// them over a valid/ready handshake through a 2-entry FIFO; pulses done at the end.
module kernel_stream_source #(
  parameter int STREAMW = 32,
  parameter int NELEMS  = 1024,
  parameter int ADDRW   = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               mem_rden,
  output logic [ADDRW-1:0]   mem_rdaddr,
  input  logic [STREAMW-1:0] mem_rddata,
  output logic               ovalid,
  input  logic               oready,
  output logic [STREAMW-1:0] out_s0
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  // One extra counter bit so NELEMS == 2**ADDRW is representable.
  localparam logic [ADDRW:0] N_TOTAL = (ADDRW+1)'(NELEMS);
  localparam logic [ADDRW:0] N_LAST  = (ADDRW+1)'(NELEMS - 1);
  localparam logic [ADDRW:0] CNT_ONE = (ADDRW+1)'(1);

  state_t             state_q, state_d;
  logic [ADDRW:0]     issued_q, issued_d;
  logic [ADDRW:0]     emitted_q, emitted_d;
  logic               inflight_q, inflight_d;
  logic [1:0]         count_q, count_d;
  logic [STREAMW-1:0] head_q, head_d;
  logic [STREAMW-1:0] tail_q, tail_d;

  logic handshake;
  logic push;

  assign ovalid    = (count_q != 2'd0);
  assign handshake = ovalid & oready;
  assign push      = inflight_q;

  always_comb begin
    // NOTE: every signal written here gets a default first so no path can
    // leave one unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    issued_d   = issued_q;
    emitted_d  = emitted_q;
    count_d    = count_q;
    head_d     = head_q;
    tail_d     = tail_q;
    mem_rden   = 1'b0;
    mem_rdaddr = issued_q[ADDRW-1:0];
    busy       = (state_q == S_RUN);
    done       = (state_q == S_DONE);
    out_s0     = ovalid ? head_q : '0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_RUN;
          issued_d  = '0;
          emitted_d = '0;
        end
      end
      S_RUN: begin
        // A read may issue into a slot that a handshake frees this same cycle.
        mem_rden = (issued_q < N_TOTAL) &&
                   (((count_q + {1'b0, inflight_q}) < 2'd2) || handshake);
        if (mem_rden)  issued_d  = issued_q + CNT_ONE;
        if (handshake) emitted_d = emitted_q + CNT_ONE;
        if (handshake && (emitted_q == N_LAST)) state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    inflight_d = mem_rden;

    count_d = count_q + {1'b0, push} - {1'b0, handshake};
    if (handshake) head_d = tail_q;
    if (push) begin
      if ((count_q - {1'b0, handshake}) == 2'd0) head_d = mem_rddata;
      else                                       tail_d = mem_rddata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      issued_q   <= '0;
      emitted_q  <= '0;
      inflight_q <= 1'b0;
      count_q    <= 2'd0;
    end else begin
      state_q    <= state_d;
      issued_q   <= issued_d;
      emitted_q  <= emitted_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
    end
  end

  // NOTE: FIFO storage is left unreset; count_q alone decides validity and
  // out_s0 is forced to zero while the FIFO is empty.
  always_ff @(posedge clk) begin
    head_q <= head_d;
    tail_q <= tail_d;
  end

endmodule
